// File: rtl/sram_pkg.sv
// sram_pkg: shared geometry constants, write-mode enum and address range helper for the frame store RAM.
package sram_pkg;

    localparam int RAM_WIDTH = 32;
    localparam int ADDR_SZ   = 20;
    localparam int RAM_DEPTH = 1 << 20;

    typedef enum logic [1:0] {
        READ_FIRST,
        WRITE_FIRST,
        NO_CHANGE
    } write_mode_e;

    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/sp_sram.sv
// sp_sram: single-port synchronous RAM with registered read data and selectable write-cycle output behaviour.
// Only the output register is reset; the array keeps its contents across rst.
module sp_sram
    import sram_pkg::*;
#(
    parameter int    DATA_W     = RAM_WIDTH,
    parameter int    ADDR_W     = ADDR_SZ,
    parameter int    DEPTH      = RAM_DEPTH,
    parameter string WRITE_MODE = "READ_FIRST"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    if (!(WRITE_MODE == "READ_FIRST" || WRITE_MODE == "WRITE_FIRST" || WRITE_MODE == "NO_CHANGE")) begin : g_bad_mode
        $error("sp_sram: illegal WRITE_MODE");
    end
    if (64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
        $error("sp_sram: DEPTH exceeds 2**ADDR_W");
    end

    localparam write_mode_e MODE = (WRITE_MODE == "WRITE_FIRST") ? WRITE_FIRST :
                                   (WRITE_MODE == "NO_CHANGE")   ? NO_CHANGE : READ_FIRST;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic              ok;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] rd_data;

    // X on en/we makes wr/rd X, which the if statements below treat as no access
    always_comb begin
        ok      = in_range(64'(addr), 64'(DEPTH));
        wr      = en & we;
        rd      = en & ~we;
        rd_data = ok ? mem[addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst && wr && ok) mem[addr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_out <= '0;
        else if (rd) data_out <= rd_data;
        else if (wr && MODE != NO_CHANGE) data_out <= (MODE == WRITE_FIRST) ? data_in : rd_data;
    end

    a_known_ctrl: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(en) && (!en || !$isunknown(we)));

endmodule

// File: tb/tb_sp_sram.sv
// tb_sp_sram: directed checks of three sp_sram variants (read-first, write-first, small no-change) driven in lockstep.
module tb_sp_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [19:0] addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] q_rf;
    logic [31:0] q_wf;
    logic [31:0] q_nc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sp_sram #(.WRITE_MODE("READ_FIRST")) dut_rf (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data_in(data_in), .data_out(q_rf));
    sp_sram #(.WRITE_MODE("WRITE_FIRST")) dut_wf (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data_in(data_in), .data_out(q_wf));
    sp_sram #(.DEPTH(1024), .WRITE_MODE("NO_CHANGE")) dut_nc (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data_in(data_in), .data_out(q_nc));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [31:0] e_rf, input logic [31:0] e_wf, input logic [31:0] e_nc);
        chk({tag, "/rf"}, q_rf, e_rf);
        chk({tag, "/wf"}, q_wf, e_wf);
        chk({tag, "/nc"}, q_nc, e_nc);
    endtask

    // drive at negedge, clock one edge, return at the next negedge for sampling
    task automatic step(input logic e, input logic w, input logic [19:0] a, input logic [31:0] d);
        en      = e;
        we      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pix(input int x, input int y);
        return {8'h00, 8'(x * 16 + y), 8'(8'hA0 + x), 8'(8'h50 + y)};
    endfunction

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk3("reset_state", 32'h0, 32'h0, 32'h0);
        rst = 1'b0;

        step(1, 1, 20'h00010, 32'hCAFE0010);
        chk3("wr_0x10", 32'h0, 32'hCAFE0010, 32'h0);
        step(1, 1, 20'h01203, 32'h00ABCDEF);
        chk3("wr_0x1203", 32'h0, 32'h00ABCDEF, 32'h0);
        step(1, 0, 20'h01203, 32'h0);
        chk3("rd_0x1203", 32'h00ABCDEF, 32'h00ABCDEF, 32'h0);

        step(1, 1, 20'h00020, 32'hDEADBEEF);
        step(1, 0, 20'h00020, 32'h0);
        chk3("rd_deadbeef", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        chk3("async_rst", 32'h0, 32'h0, 32'h0);
        en      = 1'b1;
        we      = 1'b1;
        addr    = 20'h00009;
        data_in = 32'h99;
        @(posedge clk);
        @(negedge clk);
        chk3("rst_hold", 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        step(1, 0, 20'h00010, 32'h0);
        chk3("post_rst_rd", 32'hCAFE0010, 32'hCAFE0010, 32'hCAFE0010);
        step(1, 0, 20'h00009, 32'h0);
        chk3("rst_wr_blocked", 32'h0, 32'h0, 32'h0);

        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                step(1, 1, {4'h0, 8'(x), 8'(y)}, pix(x, y));
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++) begin
                step(1, 0, {4'h0, 8'(y), 8'(x)}, 32'h0);
                chk3($sformatf("xpose_%0d_%0d", x, y), pix(y, x), pix(y, x), pix(y, x));
            end

        step(1, 0, 20'hFFFFF, 32'h0);
        chk3("rd_unwritten", 32'h0, 32'h0, 32'h0);

        step(1, 1, 20'h00000, 32'h0000000A);
        step(1, 1, 20'h00400, 32'h0000000B);
        step(1, 0, 20'h00000, 32'h0);
        chk3("no_wrap", 32'h0000000A, 32'h0000000A, 32'h0000000A);
        step(1, 0, 20'h00400, 32'h0);
        chk3("oor_rd", 32'h0000000B, 32'h0000000B, 32'h0);

        step(1, 1, 20'h00005, 32'h11);
        step(1, 0, 20'h00010, 32'h0);
        chk3("pre_collide", 32'hCAFE0010, 32'hCAFE0010, 32'hCAFE0010);
        step(1, 1, 20'h00005, 32'h22);
        chk3("collide", 32'h11, 32'h22, 32'hCAFE0010);
        step(1, 0, 20'h00005, 32'h0);
        chk3("raw_5", 32'h22, 32'h22, 32'h22);

        step(1, 1, 20'h00007, 32'h70);
        step(1, 0, 20'h00010, 32'h0);
        step(0, 1, 20'h00007, 32'h55);
        chk3("en_low_hold", 32'hCAFE0010, 32'hCAFE0010, 32'hCAFE0010);
        step(0, 0, 20'h00005, 32'h0);
        chk3("en_low_rd", 32'hCAFE0010, 32'hCAFE0010, 32'hCAFE0010);
        step(1, 0, 20'h00007, 32'h0);
        chk3("en_low_nowr", 32'h70, 32'h70, 32'h70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
